// File: rtl/home_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : home_scan_ctrl
//  Description : Programmable slot-scheduled scanner for N binary sensors and
//                one temperature input. Drives per-sensor actuators, heater
//                and cooler outputs, a display code and an event pulse.
//                Supports legacy one-hot mode and hold mode with per-sensor
//                latching/acknowledge and temperature hysteresis.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module home_scan_ctrl #(
   parameter int                         N_SENSOR = 4,
   parameter int                         SLOTS    = 13,
   parameter int                         SEL_W    = 3,
   parameter logic [SLOTS*SEL_W-1:0]     SCHED    = {3'd2, 3'd3, 3'd1, 3'd0, 3'd4, 3'd2, 3'd0,
                                                     3'd1, 3'd3, 3'd0, 3'd2, 3'd1, 3'd0},
   parameter int                         TEMP_W   = 7,
   parameter int                         TEMP_LO  = 50,
   parameter int                         TEMP_HI  = 70,
   parameter int                         HYST     = 2,
   parameter int                         MODE     = 0,
   parameter logic [N_SENSOR-1:0]        LATCH    = '0,
   localparam int                        DISP_W   = $clog2(N_SENSOR + 3),
   localparam int                        SLOT_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [N_SENSOR-1:0] s,
   input  logic [TEMP_W-1:0]   st,
   input  logic [N_SENSOR-1:0] ack,
   output logic [N_SENSOR-1:0] act,
   output logic                heater,
   output logic                cooler,
   output logic [DISP_W-1:0]   display,
   output logic [SLOT_W-1:0]   slot,
   output logic                event_pulse
);

   // Temperature thresholds, all compared unsigned at TEMP_W bits
   localparam logic [TEMP_W-1:0] C_HEAT_SET = TEMP_W'(TEMP_LO);
   localparam logic [TEMP_W-1:0] C_HEAT_CLR = TEMP_W'(TEMP_LO + HYST);
   localparam logic [TEMP_W-1:0] C_COOL_SET = TEMP_W'(TEMP_HI);
   localparam logic [TEMP_W-1:0] C_COOL_CLR = TEMP_W'(TEMP_HI - HYST);
   localparam logic [SLOT_W-1:0] C_LAST_SLOT = SLOT_W'(SLOTS - 1);
   localparam logic [SEL_W-1:0]  C_TEMP_SEL  = SEL_W'(N_SENSOR);
   // Latching only exists in hold mode; legacy mode ignores LATCH and ack
   localparam logic [N_SENSOR-1:0] C_LATCH_EFF = (MODE == 1) ? LATCH : '0;

   // Registered state
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [N_SENSOR-1:0] sens_q, sens_d;
   logic                heat_q, heat_d;
   logic                cool_q, cool_d;
   logic [N_SENSOR-1:0] act_q, act_d;
   logic                heater_q, heater_d;
   logic                cooler_q, cooler_d;
   logic [DISP_W-1:0]   disp_q, disp_d;
   logic                event_q, event_d;

   // Schedule decode
   logic [SEL_W-1:0]    w_sched [SLOTS];
   logic [SEL_W-1:0]    w_sel;
   logic [N_SENSOR-1:0] w_onehot;
   logic                w_temp;

   for (genvar k = 0; k < SLOTS; k++) begin : g_sched
      assign w_sched[k] = SCHED[k*SEL_W +: SEL_W];
   end

   assign w_sel = w_sched[slot_q];

   // Decode the current slot entry into a sensor one-hot and a temperature flag;
   // idle entries (> N_SENSOR) decode to neither
   always_comb begin
      w_onehot = '0;
      for (int i = 0; i < N_SENSOR; i++) begin
         if (w_sel == SEL_W'(i)) begin
            w_onehot[i] = 1'b1;
         end
      end
      w_temp = (w_sel == C_TEMP_SEL);
   end

   // Next-state: slot advance, channel evaluation, latch clear and output mapping
   always_comb begin
      slot_d   = slot_q;
      heat_d   = heat_q;
      cool_d   = cool_q;
      act_d    = act_q;
      heater_d = heater_q;
      cooler_d = cooler_q;
      disp_d   = disp_q;

      // Acknowledge works on latched bits regardless of en; applied before
      // evaluation so that a coincident active sample re-sets the bit
      sens_d = sens_q & ~(ack & C_LATCH_EFF);

      if (en) begin
         slot_d = (slot_q == C_LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
         disp_d = '0;

         // Sensor slot: non-latched bits follow the sample, latched bits only set
         sens_d = (sens_d & ~(w_onehot & ~C_LATCH_EFF)) | (w_onehot & s);
         for (int i = 0; i < N_SENSOR; i++) begin
            if (w_onehot[i] && s[i]) begin
               disp_d = DISP_W'(i + 1);
            end
         end

         // Temperature slot with hysteresis: between set and clear thresholds hold
         if (w_temp) begin
            if (st < C_HEAT_SET) begin
               heat_d = 1'b1;
            end else if (st >= C_HEAT_CLR) begin
               heat_d = 1'b0;
            end
            if (st > C_COOL_SET) begin
               cool_d = 1'b1;
            end else if (st <= C_COOL_CLR) begin
               cool_d = 1'b0;
            end
            if (heat_d) begin
               disp_d = DISP_W'(N_SENSOR + 1);
            end else if (cool_d) begin
               disp_d = DISP_W'(N_SENSOR + 2);
            end
         end
      end

      if (MODE == 1) begin
         // Hold mode: every output mirrors its channel state
         act_d    = sens_d;
         heater_d = heat_d;
         cooler_d = cool_d;
      end else if (en) begin
         // Legacy mode: only the channel just evaluated may be high
         act_d    = w_onehot & s;
         heater_d = w_temp & heat_d;
         cooler_d = w_temp & cool_d;
      end

      event_d = (|(act_d & ~act_q)) | (heater_d & ~heater_q) | (cooler_d & ~cooler_q);
   end

   // State and output registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q   <= '0;
         sens_q   <= '0;
         heat_q   <= 1'b0;
         cool_q   <= 1'b0;
         act_q    <= '0;
         heater_q <= 1'b0;
         cooler_q <= 1'b0;
         disp_q   <= '0;
         event_q  <= 1'b0;
      end else begin
         slot_q   <= slot_d;
         sens_q   <= sens_d;
         heat_q   <= heat_d;
         cool_q   <= cool_d;
         act_q    <= act_d;
         heater_q <= heater_d;
         cooler_q <= cooler_d;
         disp_q   <= disp_d;
         event_q  <= event_d;
      end
   end

   assign act         = act_q;
   assign heater      = heater_q;
   assign cooler      = cooler_q;
   assign display     = disp_q;
   assign slot        = slot_q;
   assign event_pulse = event_q;

endmodule
`default_nettype wire

// File: tb/tb_home_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_home_scan_ctrl
//  Description : Self-checking bench for home_scan_ctrl. One legacy-mode and
//                one hold-mode/latched instance share stimulus; a vector
//                table feeds a scoreboard queue that is checked after edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_home_scan_ctrl;

   typedef struct {
      bit         rst;     // reset both instances before applying this vector
      bit         m1;      // 1: check hold-mode instance, 0: legacy instance
      logic       en;
      logic [3:0] s;
      logic [6:0] st;
      logic [3:0] ack;
      logic [3:0] act;
      logic       heater;
      logic       cooler;
      logic [2:0] disp;
      logic [3:0] slot;
      logic       evt;
   } vec_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       en    = 1'b0;
   logic [3:0] s     = '0;
   logic [3:0] ack   = '0;
   logic [6:0] st    = '0;

   logic [3:0] a0, a1;
   logic       h0, h1, c0, c1, e0, e1;
   logic [2:0] d0, d1;
   logic [3:0] sl0, sl1;

   int checks = 0;
   int errors = 0;

   vec_t tbl[$];
   vec_t sb[$];

   int stv [6] = '{49, 51, 52, 71, 69, 68};
   bit hv  [6] = '{1, 1, 0, 0, 0, 0};
   bit cv  [6] = '{0, 0, 0, 1, 1, 0};
   int dv  [6] = '{5, 5, 0, 6, 6, 0};
   bit ev  [6] = '{1, 0, 0, 1, 0, 0};

   always #5 clk = ~clk;

   home_scan_ctrl dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .s(s), .st(st), .ack(ack),
      .act(a0), .heater(h0), .cooler(c0), .display(d0), .slot(sl0), .event_pulse(e0)
   );

   home_scan_ctrl #(.MODE(1), .LATCH(4'b0100)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .s(s), .st(st), .ack(ack),
      .act(a1), .heater(h1), .cooler(c1), .display(d1), .slot(sl1), .event_pulse(e1)
   );

   function automatic vec_t mk(bit rst, bit m1, bit en_i, logic [3:0] s_i, int st_i,
                               logic [3:0] ack_i, logic [3:0] act_e, bit h, bit c,
                               int d, int sl, bit e);
      vec_t v;
      v.rst = rst; v.m1 = m1; v.en = en_i; v.s = s_i; v.st = 7'(st_i); v.ack = ack_i;
      v.act = act_e; v.heater = h; v.cooler = c; v.disp = 3'(d); v.slot = 4'(sl); v.evt = e;
      return v;
   endfunction

   function automatic logic [13:0] pk(logic [3:0] a, logic h, logic c, logic [2:0] d,
                                      logic [3:0] sl, logic e);
      return {a, h, c, d, sl, e};
   endfunction

   function automatic logic [13:0] dut_out(bit m1);
      return m1 ? pk(a1, h1, c1, d1, sl1, e1) : pk(a0, h0, c0, d0, sl0, e0);
   endfunction

   task automatic check(string name, logic [13:0] got, logic [13:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got {act,htr,clr,disp,slot,evt}=%b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b",
                  name, got[13:10], got[9], got[8], got[7:5], got[4:1], got[0],
                  exp[13:10], exp[9], exp[8], exp[7:5], exp[4:1], exp[0]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int  j;
      bit  hit;
      vec_t v;
      vec_t e;

      // Phase A: legacy mode, front door active, ST in the comfort band
      for (int k = 1; k <= 14; k++) begin
         j   = (k - 1) % 13;
         hit = (j == 0 || j == 3 || j == 6 || j == 9);
         tbl.push_back(mk(k == 1, 0, 1, 4'b0001, 60, 4'b0000,
                          hit ? 4'b0001 : 4'b0000, 0, 0, hit ? 1 : 0, k % 13, hit));
      end

      // Phase B: legacy mode heater at slot 8, then cooler in the next frame
      for (int k = 1; k <= 23; k++) begin
         tbl.push_back(mk(k == 1, 0, 1, 4'b0000, (k <= 10) ? 49 : 71, 4'b0000, 4'b0000,
                          k == 9, k == 22, (k == 9) ? 5 : ((k == 22) ? 6 : 0), k % 13,
                          k == 9 || k == 22));
      end

      // Phase C: hold mode hysteresis, one ST value per frame
      for (int f = 0; f < 6; f++) begin
         for (int jj = 0; jj < 13; jj++) begin
            tbl.push_back(mk(f == 0 && jj == 0, 1, 1, 4'b0000, stv[f], 4'b0000, 4'b0000,
                             (jj < 8) ? ((f == 0) ? 1'b0 : hv[f-1]) : hv[f],
                             (jj < 8) ? ((f == 0) ? 1'b0 : cv[f-1]) : cv[f],
                             (jj == 8) ? dv[f] : 0, (jj + 1) % 13,
                             (jj == 8) ? ev[f] : 1'b0));
         end
      end

      // Phase D: hold mode, fire sensor latched, ack clear, ack vs. set
      for (int k = 1; k <= 18; k++) begin
         tbl.push_back(mk(k == 1, 1, 1, (k == 3 || k == 16) ? 4'b0100 : 4'b0000, 60,
                          (k == 14 || k == 16) ? 4'b0100 : 4'b0000,
                          (k < 3 || k == 14 || k == 15) ? 4'b0000 : 4'b0100, 0, 0,
                          (k == 3 || k == 16) ? 3 : 0, k % 13, k == 3 || k == 16));
      end

      // Phase E: legacy mode, scan frozen for 5 cycles at slot 4, then resumes
      tbl.push_back(mk(1, 0, 1, 4'b1001, 60, 4'b0000, 4'b0001, 0, 0, 1, 1, 1));
      tbl.push_back(mk(0, 0, 1, 4'b1001, 60, 4'b0000, 4'b0000, 0, 0, 0, 2, 0));
      tbl.push_back(mk(0, 0, 1, 4'b1001, 60, 4'b0000, 4'b0000, 0, 0, 0, 3, 0));
      tbl.push_back(mk(0, 0, 1, 4'b1001, 60, 4'b0000, 4'b0001, 0, 0, 1, 4, 1));
      for (int k = 0; k < 5; k++) begin
         tbl.push_back(mk(0, 0, 0, 4'b1001, 60, 4'b0000, 4'b0001, 0, 0, 1, 4, 0));
      end
      tbl.push_back(mk(0, 0, 1, 4'b1001, 60, 4'b0000, 4'b1000, 0, 0, 4, 5, 1));

      // Phase F: legacy mode, scan up to slot 7 with act nonzero
      for (int k = 1; k <= 7; k++) begin
         hit = (k == 1 || k == 4 || k == 7);
         tbl.push_back(mk(k == 1, 0, 1, 4'b0001, 60, 4'b0000,
                          hit ? 4'b0001 : 4'b0000, 0, 0, hit ? 1 : 0, k, hit));
      end

      // Apply the table; expectations travel through the scoreboard queue
      foreach (tbl[n]) begin
         v = tbl[n];
         if (v.rst) begin
            @(negedge clk);
            rst_n = 1'b0; en = 1'b0; s = '0; ack = '0; st = '0;
            #2;
            check("reset_legacy", dut_out(0), 14'h0);
            check("reset_hold", dut_out(1), 14'h0);
            @(negedge clk);
            rst_n = 1'b1;
         end
         en = v.en; s = v.s; st = v.st; ack = v.ack;
         sb.push_back(v);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
         end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d", n), dut_out(e.m1),
                  pk(e.act, e.heater, e.cooler, e.disp, e.slot, e.evt));
         end
      end

      // Asynchronous reset mid-scan: outputs clear before any clock edge
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_legacy", dut_out(0), 14'h0);
      check("async_reset_hold", dut_out(1), 14'h0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/home_scan_ctrl.md
Name: home_scan_ctrl

Overview:
- Parametrised successor to the fixed 13-slot home-automation sensor scanner.
- A programmable slot schedule time-multiplexes N binary sensors and one temperature input. Each sensor drives an actuator/buzzer output and a display code.
- Adds a hold mode, per-sensor latching with acknowledge, temperature hysteresis, a scan-enable input and an event pulse.
- Sits between the raw sensor inputs and the actuator/display drivers.

Parameters:
- N_SENSOR, 4: number of binary sensors. Default order is front door, rear door, fire alarm, window.
- SLOTS, 13: schedule length.
- SEL_W, 3: schedule entry width. Must satisfy 2^SEL_W > N_SENSOR.
- SCHED, {2,3,1,0,4,2,0,1,3,0,2,1,0} (slot 0 in LSBs): flat SLOTS*SEL_W vector. Slot k occupies bits [k*SEL_W +: SEL_W].
  - Entry < N_SENSOR: evaluate that sensor.
  - Entry == N_SENSOR: evaluate temperature.
  - Entry > N_SENSOR: idle slot.
- TEMP_W, 7: temperature width, unsigned.
- TEMP_LO, 50: heater on when ST < TEMP_LO.
- TEMP_HI, 70: cooler on when ST > TEMP_HI.
- HYST, 2: hysteresis band, in temperature units.
- MODE, 0:
  - 0 = legacy: only the channel evaluated in the current slot may be high.
  - 1 = hold: every channel holds its last evaluated state.
- LATCH, 0: N_SENSOR-bit mask. A set bit makes that sensor sticky until acknowledged. Effective only when MODE=1.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- En  in  1  scan enable. When low, the slot counter and evaluation freeze.
- S  in  N_SENSOR  binary sensor inputs, active high.
- ST  in  TEMP_W  temperature reading.
- Ack  in  N_SENSOR  per-sensor latch clear, level-sampled.
- act  out  N_SENSOR  per-sensor actuator/buzzer outputs, registered.
- heater  out  1  registered.
- cooler  out  1  registered.
- display  out  DISP_W = clog2(N_SENSOR+3)  code of the last evaluated event.
- slot  out  clog2(SLOTS)  index of the slot to be evaluated at the next enabled edge.
- event  out  1  one-cycle pulse on any rising channel state.

Behaviour:
- Reset (Rst_n low, asynchronous): slot=0; act, heater, cooler, display, event and all internal state = 0. Release is synchronous to the next Clk edge.
- Enabled edge (En=1): evaluate entry SCHED[slot] using S/ST sampled on that edge. Results are visible after the same edge, i.e. latency of 1 edge. Then slot advances, wrapping SLOTS-1 -> 0.
- En=0: slot, act, heater, cooler and display hold; event=0. Ack is still processed in MODE=1.
- Sensor slot, sensor i: internal st[i] = S[i] (non-latched). display = S[i] ? i+1 : 0.
- Temperature slot, with internal heat_st and cool_st:
  - heat_st: set when ST < TEMP_LO; cleared when ST >= TEMP_LO+HYST; otherwise hold.
  - cool_st: set when ST > TEMP_HI; cleared when ST <= TEMP_HI-HYST; otherwise hold.
  - display = N_SENSOR+1 if heat_st, else N_SENSOR+2 if cool_st, else 0. Uses the post-update values.
- Idle slot: display = 0, no state change.
- MODE=0 outputs:
  - After each enabled edge, only outputs of the channel just evaluated may be 1; all others are 0.
  - Temperature slot drives heater=heat_st, cooler=cool_st.
  - LATCH and Ack are ignored.
- MODE=1 outputs:
  - act = st, heater = heat_st, cooler = cool_st; all hold between their slots.
  - Latched sensor i: st[i] is set on an active sample. An inactive sample does not clear it.
  - Ack[i]=1 at any edge clears st[i]. If Ack[i] coincides with an active sample of sensor i, set wins.
  - Ack on non-latched bits is ignored.
- event = 1 for one cycle when any of act, heater or cooler goes 0 -> 1 on that edge.
- heat_st and cool_st are mutually exclusive by construction; TEMP_LO+HYST <= TEMP_HI-HYST is required.
- All comparisons are unsigned TEMP_W-bit.
- Reset asserted mid-scan aborts immediately. There is no partial-slot state.

Test Plan:
- Defaults, S=4'b0001 constant, ST=60:
  - act[0]=1, display=1 after edges 1, 4, 7 and 10 following reset release; repeats at edges 14, 17, ...
  - act=0, display=0 after all other edges.
  - slot sequence 0..12, 0.
- Defaults, ST=49, S=0:
  - after edge 9 (temperature slot 8): heater=1, display=5.
  - edge 10: heater=0, display=0.
  - ST=71 in the next frame: cooler=1, display=6 at edge 22.
- MODE=1, ST sequence per temperature slot 49, 51, 52 -> heater 1, 1, 0. ST 71, 69, 68 -> cooler 1, 1, 0.
- MODE=1, LATCH=4'b0100:
  - fire S[2]=1 only during slot 2, then 0 -> act[2] stays 1 across subsequent fire slots, event=1 once.
  - Ack[2] pulse -> act[2]=0 next edge.
  - Ack[2] on the same edge as an active fire sample -> act[2] stays 1.
- En=0 for 5 cycles at slot 4 -> slot stays 4, outputs hold. En=1 resumes evaluation at slot 4.
- Rst_n pulsed low between edges mid-scan (slot 7, act nonzero) -> act, heater, cooler, display and slot = 0 immediately, without waiting for a Clk edge.
